// File: rtl/chan_reg_bank.sv
// Register front-end for the motor channels: SPI strobe sync, address decode, read mux and
// per-channel coherent tach snapshot. Optional FRZ timeout: CHAN_REG_BANK_FREEZE_TIMEOUT_EN.
module chan_reg_bank #(
  parameter int unsigned NCHAN      = 3,
  parameter int unsigned CNTW       = 16,
  parameter int unsigned SYNCSTAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wrt_i,
  input  logic                  rdt_i,
  input  logic [5:0]            addr_i,
  input  logic [NCHAN*CNTW-1:0] cnt_i,
  input  logic [NCHAN*8-1:0]    cfgrdata_i,
  input  logic [7:0]            controlrdata_i,
  input  logic [7:0]            hwconfig_i,
  output logic [7:0]            rddata_o,
  output logic [NCHAN-1:0]      freeze_o,
  output logic [NCHAN-1:0]      pwmld_o,
  output logic [NCHAN-1:0]      cfgld_o,
  output logic                  ctrlld_o,
  output logic                  wdogdivld_o,
  output logic                  wdreset_o,
  output logic [NCHAN-1:0]      snaperr_o
);

  typedef enum logic [1:0] {StIdle, StFrz, StCap, StRel} snap_state_e;

  logic [SYNCSTAGES-1:0] wrt_sync_q, rdt_sync_q;
  logic                  wrt_hist_q, rdt_hist_q;
  logic                  wrt_s, rdt_s, we, rd_rise, rd_fall;

  logic [2:0] ch, off;
  logic       chan_hit;

  logic [7:0]       rddata_d, rddata_q;
  logic [NCHAN-1:0] pwmld_d, pwmld_q, cfgld_d, cfgld_q;
  logic             ctrlld_d, ctrlld_q, wdogdivld_d, wdogdivld_q;

  snap_state_e state_q [NCHAN];
  snap_state_e state_d [NCHAN];
  logic [23:0] shadow_q [NCHAN];
  logic [23:0] shadow_d [NCHAN];
  logic [23:0] upper;
  logic        timeout;

`ifdef CHAN_REG_BANK_FREEZE_TIMEOUT_EN
  logic [7:0]       dwell_q [NCHAN];
  logic [7:0]       dwell_d [NCHAN];
  logic [NCHAN-1:0] snaperr_q, snaperr_d;
`endif

  assign wrt_s   = wrt_sync_q[SYNCSTAGES-1];
  assign rdt_s   = rdt_sync_q[SYNCSTAGES-1];
  assign we      = wrt_hist_q & ~wrt_s;
  assign rd_rise = rdt_s & ~rdt_hist_q;
  assign rd_fall = rdt_hist_q & ~rdt_s;

  assign ch       = addr_i[5:3];
  assign off      = addr_i[2:0];
  assign chan_hit = (32'(ch) < NCHAN);

  // Write strobes and read data are registered from the decode of addr_i.
  always_comb begin
    pwmld_d     = '0;
    cfgld_d     = '0;
    ctrlld_d    = 1'b0;
    wdogdivld_d = 1'b0;
    rddata_d    = '0;
    for (int c = 0; c < NCHAN; c++) begin
      if (chan_hit && ch == 3'(c)) begin
        if (we && off == 3'd0) pwmld_d[c] = 1'b1;
        if (we && off == 3'd4) cfgld_d[c] = 1'b1;
        case (off)
          3'd0:    rddata_d = cnt_i[c*CNTW +: 8];
          3'd1:    rddata_d = shadow_q[c][7:0];
          3'd2:    rddata_d = shadow_q[c][15:8];
          3'd3:    rddata_d = shadow_q[c][23:16];
          3'd4:    rddata_d = cfgrdata_i[c*8 +: 8];
          default: rddata_d = '0;
        endcase
      end
    end
    if (addr_i == 6'h3D) rddata_d = hwconfig_i;
    if (addr_i == 6'h3F) rddata_d = controlrdata_i;
    if (we && addr_i == 6'h3E) wdogdivld_d = 1'b1;
    if (we && addr_i == 6'h3F) ctrlld_d = 1'b1;
  end

  always_comb begin
    upper   = '0;
    timeout = 1'b0;
`ifdef CHAN_REG_BANK_FREEZE_TIMEOUT_EN
    snaperr_d = snaperr_q;
`endif
    for (int c = 0; c < NCHAN; c++) begin
      state_d[c]  = state_q[c];
      shadow_d[c] = shadow_q[c];
      upper       = '0;
      upper[CNTW-9:0] = cnt_i[c*CNTW+8 +: CNTW-8];
      timeout     = 1'b0;
`ifdef CHAN_REG_BANK_FREEZE_TIMEOUT_EN
      dwell_d[c] = (state_q[c] == StFrz) ? dwell_q[c] + 8'd1 : 8'd0;
      timeout    = (state_q[c] == StFrz) && (dwell_q[c] == 8'hFF) && !rd_fall;
      if (cfgld_q[c]) snaperr_d[c] = 1'b0;
      if (timeout)    snaperr_d[c] = 1'b1;
`endif
      case (state_q[c])
        StIdle: if (rd_rise && addr_i == 6'(c*8)) state_d[c] = StFrz;
        StFrz: begin
          if (rd_fall)      state_d[c] = StCap;
          else if (timeout) state_d[c] = StRel;
        end
        StCap: begin
          shadow_d[c] = upper;
          state_d[c]  = StRel;
        end
        default: state_d[c] = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrt_sync_q  <= '0;
      rdt_sync_q  <= '0;
      wrt_hist_q  <= 1'b0;
      rdt_hist_q  <= 1'b0;
      rddata_q    <= '0;
      pwmld_q     <= '0;
      cfgld_q     <= '0;
      ctrlld_q    <= 1'b0;
      wdogdivld_q <= 1'b0;
      for (int c = 0; c < NCHAN; c++) begin
        state_q[c]  <= StIdle;
        shadow_q[c] <= '0;
`ifdef CHAN_REG_BANK_FREEZE_TIMEOUT_EN
        dwell_q[c]  <= '0;
`endif
      end
`ifdef CHAN_REG_BANK_FREEZE_TIMEOUT_EN
      snaperr_q <= '0;
`endif
    end else begin
      wrt_sync_q  <= {wrt_sync_q[SYNCSTAGES-2:0], wrt_i};
      rdt_sync_q  <= {rdt_sync_q[SYNCSTAGES-2:0], rdt_i};
      wrt_hist_q  <= wrt_s;
      rdt_hist_q  <= rdt_s;
      rddata_q    <= rddata_d;
      pwmld_q     <= pwmld_d;
      cfgld_q     <= cfgld_d;
      ctrlld_q    <= ctrlld_d;
      wdogdivld_q <= wdogdivld_d;
      for (int c = 0; c < NCHAN; c++) begin
        state_q[c]  <= state_d[c];
        shadow_q[c] <= shadow_d[c];
`ifdef CHAN_REG_BANK_FREEZE_TIMEOUT_EN
        dwell_q[c]  <= dwell_d[c];
`endif
      end
`ifdef CHAN_REG_BANK_FREEZE_TIMEOUT_EN
      snaperr_q <= snaperr_d;
`endif
    end
  end

  always_comb begin
    freeze_o = '0;
    for (int c = 0; c < NCHAN; c++) freeze_o[c] = (state_q[c] != StIdle);
  end

`ifdef CHAN_REG_BANK_FREEZE_TIMEOUT_EN
  assign snaperr_o = snaperr_q;
`else
  assign snaperr_o = '0;
`endif

  assign rddata_o    = rddata_q;
  assign pwmld_o     = pwmld_q;
  assign cfgld_o     = cfgld_q;
  assign ctrlld_o    = ctrlld_q;
  assign wdogdivld_o = wdogdivld_q;
  assign wdreset_o   = rd_fall && (addr_i == 6'h3F);

endmodule
